// File: rtl/pyjamask96_pkg.sv
// Shared Pyjamask-96 constants, FSM encoding and the round-function helpers
// used by the decryptor and its key schedule.
package pyjamask96_pkg;

    localparam int PYJ_NB_ROUNDS = 14;

    localparam logic [31:0] COL_M0     = 32'ha3861085;
    localparam logic [31:0] COL_M1     = 32'h63417021;
    localparam logic [31:0] COL_M2     = 32'h692cf280;
    localparam logic [31:0] COL_INV_M0 = 32'h2037a121;
    localparam logic [31:0] COL_INV_M1 = 32'h108ff2a0;
    localparam logic [31:0] COL_INV_M2 = 32'h9054d8c0;
    localparam logic [31:0] COL_MK     = 32'hb881b9ca;

    localparam int unsigned KS_ROT1 = 32'd8;
    localparam int unsigned KS_ROT2 = 32'd15;
    localparam int unsigned KS_ROT3 = 32'd18;

    localparam logic [31:0] KS_C0 = 32'h00000080;
    localparam logic [31:0] KS_C1 = 32'h00006a00;
    localparam logic [31:0] KS_C2 = 32'h003f0000;
    localparam logic [31:0] KS_C3 = 32'h24000000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_KS_RESET = 4'd2,
        ST_KS_STEP  = 4'd3,
        ST_ADD_KEY  = 4'd4,
        ST_INV_MIX  = 4'd5,
        ST_INV_SUB  = 4'd6,
        ST_OUT      = 4'd7,
        ST_DONE     = 4'd8
    } state_e;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        logic [63:0] dbl;
        dbl = {x, x} >> n;
        return dbl[31:0];
    endfunction

    // Circulant multiply: vector bit 31 selects the column, each lower bit a further right-rotation.
    function automatic logic [31:0] mat_mult(input logic [31:0] col, input logic [31:0] vec);
        logic [31:0] res;
        logic [31:0] c;
        res = 32'h0000_0000;
        c   = col;
        for (int i = 31; i >= 0; i--) begin
            res = res ^ (vec[i] ? c : 32'h0000_0000);
            c   = {c[0], c[31:1]};
        end
        return res;
    endfunction

    function automatic logic [95:0] inv_mix(input logic [95:0] s);
        return {mat_mult(COL_INV_M0, s[95:64]),
                mat_mult(COL_INV_M1, s[63:32]),
                mat_mult(COL_INV_M2, s[31:0])};
    endfunction

    function automatic logic [95:0] inv_sub(input logic [95:0] s);
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
        s0 = s[63:32];
        s1 = s[95:64];
        s2 = ~s[31:0];
        s0 = s0 ^ s1;
        s2 = s2 ^ s0;
        s1 = s1 ^ (s0 & s2);
        s0 = s0 ^ (s1 & s2);
        s2 = s2 ^ (s0 & s1);
        s1 = s1 ^ s2;
        s0 = s0 ^ s1;
        return {s0, s1, s2};
    endfunction

endpackage

// File: rtl/pyjamask96_key_sched.sv
// Pyjamask key schedule: master key captured byte-serially, working key
// rewound to the master key and stepped forward one round per cycle.
module pyjamask96_key_sched
    import pyjamask96_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [7:0]  key_byte_i,
    input  logic        reset_i,
    input  logic        step_i,
    output logic [95:0] round_key_o,
    output logic [3:0]  step_cnt_o
);

    logic [127:0] master_q;
    logic [127:0] key_q;
    logic [127:0] key_d;
    logic [3:0]   step_q;

    function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] k2;
        logic [31:0] k3;
        logic [31:0] m;
        m  = k[127:96] ^ k[95:64] ^ k[63:32] ^ k[31:0];
        k0 = k[127:96] ^ m;
        k1 = k[95:64]  ^ m;
        k2 = k[63:32]  ^ m;
        k3 = k[31:0]   ^ m;
        k0 = mat_mult(COL_MK, k0);
        k1 = ror32(k1, KS_ROT1);
        k2 = ror32(k2, KS_ROT2);
        k3 = ror32(k3, KS_ROT3);
        k0 = k0 ^ KS_C0 ^ {28'h000_0000, i};
        k1 = k1 ^ KS_C1;
        k2 = k2 ^ KS_C2;
        k3 = k3 ^ KS_C3;
        return {k0, k1, k2, k3};
    endfunction

    // Next working key for the current step index.
    always_comb begin
        key_d = ks_step(key_q, step_q);
    end

    // Master key shift register, working key and step counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            master_q <= 128'h0;
            key_q    <= 128'h0;
            step_q   <= 4'd0;
        end else begin
            if (load_i) begin
                master_q <= {master_q[119:0], key_byte_i};
            end
            if (reset_i) begin
                key_q  <= master_q;
                step_q <= 4'd0;
            end else if (step_i) begin
                key_q  <= key_d;
                step_q <= (step_q == 4'd15) ? step_q : step_q + 4'd1;
            end
        end
    end

    assign round_key_o = key_q[127:32];
    assign step_cnt_o  = step_q;

endmodule

// File: rtl/pyjamask96_dec.sv
// Byte-serial Pyjamask-96 decryptor: loads ciphertext and key, runs the
// inverse rounds with an on-the-fly key schedule, then streams plaintext.
module pyjamask96_dec
    import pyjamask96_pkg::*;
#(
    parameter int NB_ROUNDS = PYJ_NB_ROUNDS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic [7:0] byte_key_in,
    output logic       valid,
    output logic [7:0] byte_out
);

    state_e      state_q;
    logic [95:0] data_q;
    logic [4:0]  load_cnt_q;
    logic [3:0]  round_q;
    logic [3:0]  out_cnt_q;
    logic        valid_q;
    logic [7:0]  byte_out_q;

    logic        key_shift_s;
    logic        ks_reset_s;
    logic        ks_step_s;
    logic [95:0] round_key_s;
    logic [3:0]  step_cnt_s;
    logic [7:0]  out_byte_s;

    // Key-schedule controls and the output byte selected by the output counter.
    always_comb begin
        key_shift_s = ((state_q == ST_IDLE) && load) ||
                      ((state_q == ST_LOAD) && (load_cnt_q != 5'd16));
        ks_reset_s  = (state_q == ST_KS_RESET);
        ks_step_s   = (state_q == ST_KS_STEP);
        out_byte_s  = 8'h00;
        for (int j = 0; j < 12; j++) begin
            out_byte_s = (out_cnt_q == 4'(j)) ? data_q[95 - 8*j -: 8] : out_byte_s;
        end
    end

    pyjamask96_key_sched u_key_sched (
        .clk_i       (clk),
        .rst_n_i     (reset_n),
        .load_i      (key_shift_s),
        .key_byte_i  (byte_key_in),
        .reset_i     (ks_reset_s),
        .step_i      (ks_step_s),
        .round_key_o (round_key_s),
        .step_cnt_o  (step_cnt_s)
    );

    // Main sequencer: load, 15 key additions with 14 inverse rounds between, output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            data_q     <= 96'h0;
            load_cnt_q <= 5'd0;
            round_q    <= 4'd0;
            out_cnt_q  <= 4'd0;
            valid_q    <= 1'b0;
            byte_out_q <= 8'h00;
        end else begin
            valid_q    <= 1'b0;
            byte_out_q <= 8'h00;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        data_q     <= {data_q[87:0], byte_in};
                        load_cnt_q <= 5'd1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_cnt_q != 5'd16) begin
                        // Only the first 12 bytes are ciphertext; the last 4 carry key only.
                        if (load_cnt_q < 5'd12) begin
                            data_q <= {data_q[87:0], byte_in};
                        end
                        load_cnt_q <= load_cnt_q + 5'd1;
                    end else if (start) begin
                        round_q <= 4'(NB_ROUNDS);
                        state_q <= ST_KS_RESET;
                    end
                end
                ST_KS_RESET: begin
                    state_q <= (round_q == 4'd0) ? ST_ADD_KEY : ST_KS_STEP;
                end
                ST_KS_STEP: begin
                    if ((step_cnt_s + 4'd1) == round_q) begin
                        state_q <= ST_ADD_KEY;
                    end
                end
                ST_ADD_KEY: begin
                    data_q <= data_q ^ round_key_s;
                    if (round_q == 4'd0) begin
                        out_cnt_q <= 4'd0;
                        state_q   <= ST_OUT;
                    end else begin
                        state_q <= ST_INV_MIX;
                    end
                end
                ST_INV_MIX: begin
                    data_q  <= inv_mix(data_q);
                    state_q <= ST_INV_SUB;
                end
                ST_INV_SUB: begin
                    data_q  <= inv_sub(data_q);
                    round_q <= round_q - 4'd1;
                    state_q <= ST_KS_RESET;
                end
                ST_OUT: begin
                    valid_q    <= 1'b1;
                    byte_out_q <= out_byte_s;
                    if (out_cnt_q == 4'd11) begin
                        state_q <= ST_DONE;
                    end else begin
                        out_cnt_q <= out_cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    load_cnt_q <= 5'd0;
                    out_cnt_q  <= 4'd0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid    = valid_q;
    assign byte_out = byte_out_q;

endmodule

// File: tb/tb_pyjamask96_dec.sv
// Directed bench for pyjamask96_dec: a local Pyjamask-96 model encrypts
// plaintexts, the DUT decrypts them, and the recovered bytes are compared.
module tb_pyjamask96_dec;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load;
    logic       start;
    logic [7:0] byte_in;
    logic [7:0] byte_key_in;
    logic       valid;
    logic [7:0] byte_out;

    int errors = 0;
    int checks = 0;

    pyjamask96_dec dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .start       (start),
        .byte_in     (byte_in),
        .byte_key_in (byte_key_in),
        .valid       (valid),
        .byte_out    (byte_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
        return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
    endfunction

    function automatic logic [31:0] m_mat(input logic [31:0] col, input logic [31:0] v);
        logic [31:0] res;
        res = 32'h0;
        for (int j = 0; j < 32; j++) begin
            res = res ^ (v[31 - j] ? m_ror(col, j) : 32'h0);
        end
        return res;
    endfunction

    function automatic logic [95:0] m_inv_mix(input logic [95:0] s);
        return {m_mat(32'h2037a121, s[95:64]), m_mat(32'h108ff2a0, s[63:32]), m_mat(32'h9054d8c0, s[31:0])};
    endfunction

    // An invertible 32x32 binary circulant has order dividing 32, so its inverse is its 31st power.
    function automatic logic [95:0] m_mix(input logic [95:0] s);
        logic [95:0] t;
        t = s;
        for (int n = 0; n < 31; n++) t = m_inv_mix(t);
        return t;
    endfunction

    function automatic logic [95:0] m_inv_sub(input logic [95:0] s);
        logic [31:0] s0, s1, s2, t;
        s0 = s[95:64]; s1 = s[63:32]; s2 = s[31:0];
        t = s0; s0 = s1; s1 = t;
        s2 = ~s2;
        s0 ^= s1; s2 ^= s0; s1 ^= s0 & s2; s0 ^= s1 & s2; s2 ^= s0 & s1; s1 ^= s2; s0 ^= s1;
        return {s0, s1, s2};
    endfunction

    function automatic logic [95:0] m_sub(input logic [95:0] s);
        logic [31:0] s0, s1, s2, t;
        s0 = s[95:64]; s1 = s[63:32]; s2 = s[31:0];
        s0 ^= s1; s1 ^= s2; s2 ^= s0 & s1; s0 ^= s1 & s2; s1 ^= s0 & s2; s2 ^= s0; s0 ^= s1;
        s2 = ~s2;
        t = s0; s0 = s1; s1 = t;
        return {s0, s1, s2};
    endfunction

    function automatic logic [127:0] m_ks(input logic [127:0] k, input int i);
        logic [31:0] k0, k1, k2, k3, m;
        k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
        m = k0 ^ k1 ^ k2 ^ k3;
        k0 ^= m; k1 ^= m; k2 ^= m; k3 ^= m;
        k0 = m_mat(32'hb881b9ca, k0);
        k1 = m_ror(k1, 8); k2 = m_ror(k2, 15); k3 = m_ror(k3, 18);
        k0 ^= 32'h00000080 ^ 32'(i);
        k1 ^= 32'h00006a00; k2 ^= 32'h003f0000; k3 ^= 32'h24000000;
        return {k0, k1, k2, k3};
    endfunction

    function automatic logic [95:0] m_enc(input logic [127:0] key, input logic [95:0] pt);
        logic [127:0] k;
        logic [95:0]  s;
        k = key; s = pt;
        for (int r = 0; r < 14; r++) begin
            s = m_mix(m_sub(s ^ k[127:32]));
            k = m_ks(k, r);
        end
        return s ^ k[127:32];
    endfunction

    function automatic logic [95:0] m_dec(input logic [127:0] key, input logic [95:0] ct);
        logic [127:0] rk [0:14];
        logic [95:0]  s;
        rk[0] = key;
        for (int r = 1; r <= 14; r++) rk[r] = m_ks(rk[r-1], r - 1);
        s = ct ^ rk[14][127:32];
        for (int r = 13; r >= 0; r--) s = m_inv_sub(m_inv_mix(s)) ^ rk[r][127:32];
        return s;
    endfunction

    // Loads key/ciphertext, starts, and records the output window for 180 cycles after start.
    task automatic run_op(input logic [127:0] key, input logic [95:0] ct, input int early_start,
                          input int load_at, input int rst_at, output logic [95:0] pt,
                          output int first, output int nvalid, output int last,
                          output logic v_rst, output logic [7:0] b_rst);
        logic [95:0]  csh;
        logic [127:0] ksh;
        pt = 96'h0; first = 0; nvalid = 0; last = 0; v_rst = 1'b0; b_rst = 8'h00;
        csh = ct; ksh = key;
        for (int c = 0; c < 16; c++) begin
            load        = (c == 0);
            start       = (c == early_start);
            byte_in     = (c < 12) ? csh[95:88] : 8'hA5;
            byte_key_in = ksh[127:120];
            csh = csh << 8;
            ksh = ksh << 8;
            @(posedge clk); #1;
        end
        load = 1'b0; byte_in = 8'h00; byte_key_in = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cnt = 1; cnt <= 180; cnt++) begin
            @(posedge clk); #1;
            load        = (cnt == load_at);
            byte_in     = load ? 8'hFF : 8'h00;
            byte_key_in = load ? 8'hFF : 8'h00;
            if (cnt == rst_at) begin
                reset_n = 1'b0;
                #1;
                v_rst = valid;
                b_rst = byte_out;
            end
            if (cnt == rst_at + 2) reset_n = 1'b1;
            if (valid === 1'b1) begin
                if (first == 0) first = cnt;
                last = cnt;
                nvalid++;
                pt = {pt[87:0], byte_out};
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        reset_n = 1'b0; load = 1'b0; start = 1'b0; byte_in = 8'h00; byte_key_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", byte_out); end
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            start = c[0];
            @(posedge clk); #1;
            if (valid !== 1'b0) seen++;
        end
        start = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL idle_start_ignored: valid cycles %0d expected 0", seen); end
    endtask

    task automatic test_components();
        logic [95:0] x;
        for (int p = 0; p < 98; p++) begin
            x = (p == 0) ? 96'h0 : (p == 1) ? {96{1'b1}} : (96'h1 << (p - 2));
            checks++;
            if (m_inv_sub(m_sub(x)) !== x) begin errors++; $display("FAIL comp_sub: got %h expected %h", m_inv_sub(m_sub(x)), x); end
            checks++;
            if (m_inv_mix(m_mix(x)) !== x) begin errors++; $display("FAIL comp_mix: got %h expected %h", m_inv_mix(m_mix(x)), x); end
        end
    endtask

    task automatic test_known(input int early_start, input int load_at, input string tag);
        logic [127:0] key;
        logic [95:0]  pt_exp, pt;
        int first, nvalid, last;
        logic v_rst;
        logic [7:0] b_rst;
        key    = 128'h000102030405060708090a0b0c0d0e0f;
        pt_exp = 96'h000102030405060708090a0b;
        run_op(key, m_enc(key, pt_exp), early_start, load_at, 0, pt, first, nvalid, last, v_rst, b_rst);
        checks++; if (pt !== pt_exp) begin errors++; $display("FAIL %s_plaintext: got %h expected %h", tag, pt, pt_exp); end
        checks++; if (first !== 164) begin errors++; $display("FAIL %s_latency: got %0d expected 164", tag, first); end
        checks++; if (nvalid !== 12) begin errors++; $display("FAIL %s_valid_count: got %0d expected 12", tag, nvalid); end
        checks++; if (last !== 175) begin errors++; $display("FAIL %s_valid_last: got %0d expected 175", tag, last); end
    endtask

    task automatic test_random();
        logic [127:0] key;
        logic [95:0]  ptx, pt;
        int first, nvalid, last;
        logic v_rst;
        logic [7:0] b_rst;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            ptx = {$urandom(), $urandom(), $urandom()};
            checks++;
            if (m_dec(key, m_enc(key, ptx)) !== ptx) begin errors++; $display("FAIL model_roundtrip: got %h expected %h", m_dec(key, m_enc(key, ptx)), ptx); end
        end
        for (int n = 0; n < 24; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            ptx = {$urandom(), $urandom(), $urandom()};
            run_op(key, m_enc(key, ptx), -1, 0, 0, pt, first, nvalid, last, v_rst, b_rst);
            checks++; if (pt !== ptx) begin errors++; $display("FAIL random_plaintext: got %h expected %h", pt, ptx); end
            checks++; if (nvalid !== 12 || first !== 164) begin errors++; $display("FAIL random_window: got first %0d count %0d expected 164/12", first, nvalid); end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] key;
        logic [95:0]  ptx, pt;
        int first, nvalid, last;
        logic v_rst;
        logic [7:0] b_rst;
        int rst_pts [2];
        int exp_cnt [2];
        rst_pts = '{80, 170};
        exp_cnt = '{0, 6};
        for (int t = 0; t < 2; t++) begin
            key = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0 ^ 128'(t);
            ptx = 96'hdeadbeef0123456789abcdef ^ 96'(t);
            run_op(key, m_enc(key, ptx), -1, 0, rst_pts[t], pt, first, nvalid, last, v_rst, b_rst);
            checks++; if (v_rst !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", v_rst); end
            checks++; if (b_rst !== 8'h00) begin errors++; $display("FAIL midreset_byte: got %h expected 00", b_rst); end
            checks++; if (nvalid !== exp_cnt[t]) begin errors++; $display("FAIL midreset_count: got %0d expected %0d", nvalid, exp_cnt[t]); end
            run_op(key, m_enc(key, ptx), -1, 0, 0, pt, first, nvalid, last, v_rst, b_rst);
            checks++; if (pt !== ptx || first !== 164) begin errors++; $display("FAIL after_reset: got %h at %0d expected %h at 164", pt, first, ptx); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, kb;
        logic [95:0]  pa, pb, pt;
        int first, nvalid, last;
        logic v_rst;
        logic [7:0] b_rst;
        ka = 128'h00112233445566778899aabbccddeeff; pa = 96'h0123456789abcdef01234567;
        kb = 128'hffeeddccbbaa99887766554433221100; pb = 96'hfedcba9876543210fedcba98;
        run_op(ka, m_enc(ka, pa), -1, 0, 0, pt, first, nvalid, last, v_rst, b_rst);
        checks++; if (pt !== pa) begin errors++; $display("FAIL b2b_first: got %h expected %h", pt, pa); end
        checks++; if (first !== 164 || nvalid !== 12) begin errors++; $display("FAIL b2b_first_window: got %0d/%0d expected 164/12", first, nvalid); end
        run_op(kb, m_enc(kb, pb), -1, 0, 0, pt, first, nvalid, last, v_rst, b_rst);
        checks++; if (pt !== pb) begin errors++; $display("FAIL b2b_second: got %h expected %h", pt, pb); end
        checks++; if (first !== 164 || nvalid !== 12) begin errors++; $display("FAIL b2b_second_window: got %0d/%0d expected 164/12", first, nvalid); end
    endtask

    initial begin
        test_reset();
        test_components();
        test_known(-1, 0, "known");
        test_known(10, 50, "ignored");
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pyjamask96_dec.md
PYJAMASK96_DEC -- requirements
Module: pyjamask96_dec

Interface
REQ-001 NB_ROUNDS, default 14, number of cipher rounds.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 load  input  1  in IDLE, begins byte loading; byte_in/byte_key_in are sampled on that same edge.
REQ-005 start  input  1  in LOAD with all 16 key bytes captured, begins decryption.
REQ-006 byte_in  input  8  ciphertext byte, most significant byte first.
REQ-007 byte_key_in  input  8  key byte, most significant byte first.
REQ-008 valid  output  1  high while byte_out carries plaintext.
REQ-009 byte_out  output  8  plaintext byte, most significant byte first.

Function
REQ-010 The block SHALL have FSM states IDLE, LOAD, KS_RESET, KS_STEP, ADD_KEY, INV_MIX, INV_SUB, OUT, DONE.
REQ-011 Loading SHALL capture 16 cycles: cycles 0-11 shift byte_in into the 96-bit state and byte_key_in into the 128-bit key; cycles 12-15 shift the key only; byte_in is ignored in cycles 12-15.
REQ-012 The loaded key SHALL be held unchanged in a master-key register until the next load.
REQ-013 start before the 16th key byte is captured SHALL be ignored; start in any state other than LOAD SHALL be ignored; load outside IDLE SHALL be ignored.
REQ-014 The key-schedule step for index i SHALL apply three operations in order: (1) MixColumns: XOR each 32-bit row with the XOR of all four rows; (2) row 0 multiplied by circulant column 0xb881b9ca, rows 1/2/3 rotated right by 8/15/18; (3) row 0 ^= 0x00000080 ^ i (i in the low 4 bits), row 1 ^= 0x00006a00, row 2 ^= 0x003f0000, row 3 ^= 0x24000000.
REQ-015 Round key K_r SHALL be obtained by KS_RESET (working key <= master key, 1 cycle) followed by r KS_STEP cycles, using i = 0..r-1; K_r uses the upper 96 bits of the working key.
REQ-016 The decryption sequence SHALL be: state ^= K_14; then for r = 13 down to 0: INV_MIX, INV_SUB, state ^= K_r.
REQ-017 INV_MIX SHALL multiply rows 0/1/2 by circulant columns 0x2037a121 / 0x108ff2a0 / 0x9054d8c0, using the same column-rotating multiply as the forward mix.
REQ-018 INV_SUB SHALL apply, bitwise on rows s0,s1,s2, in order: swap s0,s1; s2=~s2; s0^=s1; s2^=s0; s1^=s0&s2; s0^=s1&s2; s2^=s0&s1; s1^=s2; s0^=s1.
REQ-019 Per key index r: KS_RESET (1 cycle), KS_STEP (r cycles, skipped when r=0), ADD_KEY (1 cycle); then INV_MIX and INV_SUB (1 cycle each) when r>0. The start-to-first-valid latency SHALL be exactly 164 cycles.
REQ-020 OUT SHALL assert valid for exactly 12 consecutive cycles, emitting state bytes 0..11 in order; then DONE (1 cycle, valid=0); then IDLE.
REQ-021 The round counter SHALL count down from 14, and the step counter SHALL count up to r; neither SHALL wrap.
REQ-022 After DONE, the state, key and master key SHALL be overwritten only by the next load.

Reset
REQ-023 Assertion of reset_n at any time, including mid-load, mid-decrypt or mid-output, SHALL force IDLE, valid=0, byte_out=0, and clear all counters, state, key and master key.
REQ-024 After reset release, the block SHALL be idle until load is asserted.

Structure
REQ-025 The Pyjamask-96 constants (NB_ROUNDS, forward and inverse mix columns, key matrix column, rotation amounts, key constants) SHALL reside in the shared Pyjamask package.
REQ-026 The key-schedule register, master key, step counter and step function SHALL be a sub-module named pyjamask96_key_sched.

Verification
REQ-027 Key 000102..0f, ciphertext = the 96-bit encryption of plaintext 000102..0b -> byte_out 00,01,..,0b with valid high for 12 cycles, first valid exactly 164 cycles after start.
REQ-028 Random key/plaintext pairs (>=1000), each encrypted and then decrypted -> the original plaintext every time.
REQ-029 Component check: INV_SUB(SUB(x)) == x and INV_MIX(MIX(x)) == x for x = 0, all-ones, walking single-one patterns.
REQ-030 reset_n pulsed low at the 80th cycle after start -> valid=0 immediately; the following full load/start sequence decrypts correctly.
REQ-031 start pulsed at load cycle 10, and load pulsed during decryption -> both ignored; output matches REQ-027.
REQ-032 Two back-to-back operations with different keys -> each output correct; no carry-over of key or counters.
